munoc_burst_addr_arbiter: RTL and testbench



---
 rtl/munoc_burst_addr_arbiter_pkg.sv | 28 ++
 rtl/munoc_rr_arbiter2.sv | 38 +++
 rtl/munoc_burst_addr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_munoc_burst_addr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/munoc_burst_addr_arbiter_pkg.sv
// Shared encodings for the MUNOC burst address arbiter: FSM states, grant sides, AXI burst constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package munoc_burst_addr_arbiter_pkg;

    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_W = 2'd1,
        ST_RUN_R = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_W = 1'b0,
        GRANT_R = 1'b1
    } grant_t;

    // The generator has no defined behaviour for the reserved type, so it is run as INCR.
    function automatic logic [AXI_BURST_W-1:0] burst_sanitize(input logic [AXI_BURST_W-1:0] burst);
        return (burst == AXI_BURST_RSVD) ? AXI_BURST_INCR : burst;
    endfunction

endpackage

// File: rtl/munoc_rr_arbiter2.sv
// Two-requester round-robin picker; prio_w forces write to win a tie.
// Latency: grant is combinational from the requests; last_grant updates on the clock after a grant.
// Backpressure: none; callers gate req_* to the cycles in which a grant may be taken.
module munoc_rr_arbiter2
    import munoc_burst_addr_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_w,
    input  logic   req_r,
    input  logic   prio_w,
    output logic   gnt_vld,
    output grant_t gnt
);

    grant_t last_grant;

    // Pick a side: lone requester wins, a tie goes opposite the previous winner unless prio_w.
    always_comb begin
        gnt_vld = req_w | req_r;
        gnt     = GRANT_W;
        if (req_w && req_r) begin
            gnt = (prio_w || (last_grant == GRANT_R)) ? GRANT_W : GRANT_R;
        end else if (req_r) begin
            gnt = GRANT_R;
        end
    end

    // Remember who won; starting at READ lets write take the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_R;
        end else if (gnt_vld) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/munoc_burst_addr_arbiter.sv
// Shares one AXI burst address generator between AW and AR requests and steers its beats back.
// Latency: request accepted combinationally in IDLE at cycle c, first beat valid at c+1, one idle bubble between bursts.
// Backpressure: xbeat_ready=0 holds beat valid/address/counter; no request accepted while a burst runs.
// Option: define MUNOC_BURST_ARB_WRITE_PRIORITY_EN for fixed write-wins-tie priority instead of round robin.
module munoc_burst_addr_arbiter
    import munoc_burst_addr_arbiter_pkg::*;
#(
    parameter int BW_ADDR = 32,
    parameter int BW_LEN  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wreq_valid,
    output logic                   wreq_ready,
    input  logic [BW_ADDR-1:0]     wreq_addr,
    input  logic [BW_LEN-1:0]      wreq_len,
    input  logic [AXI_SIZE_W-1:0]  wreq_size,
    input  logic [AXI_BURST_W-1:0] wreq_burst,
    input  logic                   rreq_valid,
    output logic                   rreq_ready,
    input  logic [BW_ADDR-1:0]     rreq_addr,
    input  logic [BW_LEN-1:0]      rreq_len,
    input  logic [AXI_SIZE_W-1:0]  rreq_size,
    input  logic [AXI_BURST_W-1:0] rreq_burst,
    output logic                   gen_start,
    output logic [BW_ADDR-1:0]     gen_addr_o,
    output logic [BW_LEN-1:0]      gen_len,
    output logic [AXI_SIZE_W-1:0]  gen_size,
    output logic [AXI_BURST_W-1:0] gen_burst,
    input  logic [BW_ADDR-1:0]     gen_addr_i,
    input  logic                   gen_last,
    output logic                   gen_next,
    output logic                   wbeat_valid,
    input  logic                   wbeat_ready,
    output logic [BW_ADDR-1:0]     wbeat_addr,
    output logic                   wbeat_last,
    output logic                   rbeat_valid,
    input  logic                   rbeat_ready,
    output logic [BW_ADDR-1:0]     rbeat_addr,
    output logic                   rbeat_last,
    output logic                   busy,
    output logic                   err_burst
);

    state_t              state, state_nxt;
    logic [BW_LEN-1:0]   beat_cnt, beat_cnt_nxt;
    logic                err_burst_nxt;
    logic                arb_req_w, arb_req_r, arb_prio_w, gnt_vld;
    grant_t              gnt;
    logic [AXI_BURST_W-1:0] sel_burst;
    logic                cnt_zero;

    // Sequencing runs off the local beat counter; the generator's own last flag is not needed.
    logic unused_gen_last;
    assign unused_gen_last = gen_last;

`ifdef MUNOC_BURST_ARB_WRITE_PRIORITY_EN
    assign arb_prio_w = 1'b1;
`else
    assign arb_prio_w = 1'b0;
`endif

    // Requests only compete in IDLE and never while reset is held.
    assign arb_req_w = (state == ST_IDLE) && !rst && wreq_valid;
    assign arb_req_r = (state == ST_IDLE) && !rst && rreq_valid;
    assign sel_burst = (gnt == GRANT_R) ? rreq_burst : wreq_burst;
    assign cnt_zero  = (beat_cnt == '0);

    munoc_rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_w   (arb_req_w),
        .req_r   (arb_req_r),
        .prio_w  (arb_prio_w),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    // Next state, beat counter and all handshake outputs.
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        err_burst_nxt = err_burst;
        wreq_ready    = 1'b0;
        rreq_ready    = 1'b0;
        gen_start     = 1'b0;
        gen_addr_o    = '0;
        gen_len       = '0;
        gen_size      = '0;
        gen_burst     = '0;
        gen_next      = 1'b0;
        wbeat_valid   = 1'b0;
        wbeat_addr    = '0;
        wbeat_last    = 1'b0;
        rbeat_valid   = 1'b0;
        rbeat_addr    = '0;
        rbeat_last    = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    gen_start  = 1'b1;
                    gen_burst  = burst_sanitize(sel_burst);
                    if (sel_burst == AXI_BURST_RSVD) begin
                        err_burst_nxt = 1'b1;
                    end
                    if (gnt == GRANT_R) begin
                        rreq_ready   = 1'b1;
                        gen_addr_o   = rreq_addr;
                        gen_len      = rreq_len;
                        gen_size     = rreq_size;
                        beat_cnt_nxt = rreq_len;
                        state_nxt    = ST_RUN_R;
                    end else begin
                        wreq_ready   = 1'b1;
                        gen_addr_o   = wreq_addr;
                        gen_len      = wreq_len;
                        gen_size     = wreq_size;
                        beat_cnt_nxt = wreq_len;
                        state_nxt    = ST_RUN_W;
                    end
                end
            end
            ST_RUN_W: begin
                busy        = 1'b1;
                wbeat_valid = 1'b1;
                wbeat_addr  = gen_addr_i;
                wbeat_last  = cnt_zero;
                if (wbeat_ready) begin
                    gen_next = 1'b1;
                    if (cnt_zero) state_nxt = ST_IDLE;
                    else          beat_cnt_nxt = beat_cnt - BW_LEN'(1);
                end
            end
            ST_RUN_R: begin
                busy        = 1'b1;
                rbeat_valid = 1'b1;
                rbeat_addr  = gen_addr_i;
                rbeat_last  = cnt_zero;
                if (rbeat_ready) begin
                    gen_next = 1'b1;
                    if (cnt_zero) state_nxt = ST_IDLE;
                    else          beat_cnt_nxt = beat_cnt - BW_LEN'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, beat counter and sticky reserved-burst flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            err_burst <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            err_burst <= err_burst_nxt;
        end
    end

endmodule

// File: tb/tb_munoc_burst_addr_arbiter.sv
`timescale 1ns/1ps
module tb_munoc_burst_addr_arbiter;

    localparam int BW_ADDR = 32;
    localparam int BW_LEN  = 8;
`ifdef MUNOC_BURST_ARB_WRITE_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wreq_valid = 0, rreq_valid = 0, wreq_ready, rreq_ready;
    logic [31:0] wreq_addr = 0, rreq_addr = 0;
    logic [7:0]  wreq_len = 0, rreq_len = 0;
    logic [2:0]  wreq_size = 0, rreq_size = 0;
    logic [1:0]  wreq_burst = 0, rreq_burst = 0;
    logic gen_start, gen_next, gen_last;
    logic [31:0] gen_addr_o, gen_addr_i;
    logic [7:0]  gen_len;
    logic [2:0]  gen_size;
    logic [1:0]  gen_burst;
    logic wbeat_valid, wbeat_last, rbeat_valid, rbeat_last;
    logic wbeat_ready = 0, rbeat_ready = 0;
    logic [31:0] wbeat_addr, rbeat_addr;
    logic busy, err_burst;

    munoc_burst_addr_arbiter #(.BW_ADDR(BW_ADDR), .BW_LEN(BW_LEN)) dut (
        .clk(clk), .rst(rst),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
        .wreq_len(wreq_len), .wreq_size(wreq_size), .wreq_burst(wreq_burst),
        .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
        .rreq_len(rreq_len), .rreq_size(rreq_size), .rreq_burst(rreq_burst),
        .gen_start(gen_start), .gen_addr_o(gen_addr_o), .gen_len(gen_len),
        .gen_size(gen_size), .gen_burst(gen_burst), .gen_addr_i(gen_addr_i),
        .gen_last(gen_last), .gen_next(gen_next),
        .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready), .wbeat_addr(wbeat_addr), .wbeat_last(wbeat_last),
        .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready), .rbeat_addr(rbeat_addr), .rbeat_last(rbeat_last),
        .busy(busy), .err_burst(err_burst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in address generator: latches the launch, steps by 2^size per beat (FIXED holds).
    logic [31:0] g_addr;
    logic [7:0]  g_rem;
    logic [2:0]  g_size;
    logic [1:0]  g_burst;
    always @(posedge clk) begin
        if (rst) begin
            g_addr <= 0; g_rem <= 0; g_size <= 0; g_burst <= 0;
        end else if (gen_start) begin
            g_addr <= gen_addr_o; g_rem <= gen_len; g_size <= gen_size; g_burst <= gen_burst;
        end else if (gen_next) begin
            if (g_burst != 2'b00) g_addr <= g_addr + (32'd1 << g_size);
            if (g_rem != 0) g_rem <= g_rem - 8'd1;
        end
    end
    assign gen_addr_i = g_addr;
    assign gen_last   = (g_rem == 8'd0);

    // Behavioural model: a queue of beat addresses still owed to the owning side.
    logic [31:0] m_q[$];
    int          m_side = 0;          // 0 idle, 1 write, 2 read
    logic        m_last_r = 1'b1;
    logic        m_err = 1'b0;
    int          grant_log[$];
    int          dut_next_cnt = 0, dut_wbeats = 0, dut_rbeats = 0;

    always @(negedge clk) begin : model
        int g;
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        logic        rdy;
        if (rst) begin
            m_q.delete(); m_side = 0; m_last_r = 1'b1; m_err = 1'b0;
        end else begin
            if (gen_next) dut_next_cnt++;
            if (wbeat_valid && wbeat_ready) dut_wbeats++;
            if (rbeat_valid && rbeat_ready) dut_rbeats++;
            g = 0; b = 0;
            chk("err_burst", err_burst, m_err);
            if (m_side == 0) begin
                if (wreq_valid && rreq_valid) g = (PRIO || m_last_r) ? 1 : 2;
                else if (wreq_valid)          g = 1;
                else if (rreq_valid)          g = 2;
                chk("wreq_ready", wreq_ready, g == 1);
                chk("rreq_ready", rreq_ready, g == 2);
                chk("gen_start", gen_start, g != 0);
                chk("busy_idle", busy, 0);
                chk("beat_valid_idle", {wbeat_valid, rbeat_valid, gen_next}, 0);
                if (g != 0) begin
                    a = (g == 1) ? wreq_addr  : rreq_addr;
                    l = (g == 1) ? wreq_len   : rreq_len;
                    s = (g == 1) ? wreq_size  : rreq_size;
                    b = (g == 1) ? wreq_burst : rreq_burst;
                    chk("gen_addr_o", gen_addr_o, a);
                    chk("gen_len", gen_len, l);
                    chk("gen_size", gen_size, s);
                    chk("gen_burst", gen_burst, (b == 2'b11) ? 2'b01 : b);
                    for (int i = 0; i <= int'(l); i++)
                        m_q.push_back(a + ((b == 2'b00) ? 32'd0 : (32'(i) << s)));
                    m_side   = g;
                    m_last_r = (g == 2);
                    if (b == 2'b11) m_err = 1'b1;
                    grant_log.push_back(g);
                end
            end else begin
                chk("req_ready_busy", {wreq_ready, rreq_ready, gen_start}, 0);
                chk("busy_run", busy, 1);
                chk("wbeat_valid", wbeat_valid, m_side == 1);
                chk("rbeat_valid", rbeat_valid, m_side == 2);
                if (m_side == 1) begin
                    chk("wbeat_addr", wbeat_addr, m_q[0]);
                    chk("wbeat_last", wbeat_last, m_q.size() == 1);
                end else begin
                    chk("rbeat_addr", rbeat_addr, m_q[0]);
                    chk("rbeat_last", rbeat_last, m_q.size() == 1);
                end
                chk("gen_last_xcheck", gen_last, m_q.size() == 1);
                rdy = (m_side == 1) ? wbeat_ready : rbeat_ready;
                chk("gen_next", gen_next, rdy);
                if (rdy) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_side = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one request and hold it until accepted; returns in the first beat cycle.
    task automatic send(input bit is_w, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b, output logic [1:0] launched_burst);
        bit hs;
        hs = 0;
        launched_burst = 2'bxx;
        if (is_w) begin wreq_valid = 1; wreq_addr = a; wreq_len = l; wreq_size = s; wreq_burst = b; end
        else      begin rreq_valid = 1; rreq_addr = a; rreq_len = l; rreq_size = s; rreq_burst = b; end
        for (int c = 0; c < 600 && !hs; c++) begin
            @(negedge clk);
            hs = is_w ? (wreq_valid && wreq_ready && !rst) : (rreq_valid && rreq_ready && !rst);
            if (hs) launched_burst = gen_burst;
            step();
        end
        if (is_w) wreq_valid = 0; else rreq_valid = 0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout: side=%0d not accepted within budget", is_w);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = !busy && !wreq_valid && !rreq_valid;
            if (!done) step();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
        step();
    endtask

    initial begin : stim
        logic [1:0] lb;
        int n0, w0;
        int exp_order[4];
        bit w_pend, r_pend;

        // Reset state, including a request held during reset that must not be accepted.
        wreq_valid = 1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_wreq_ready", wreq_ready, 0);
        chk("rst_gen_start", gen_start, 0);
        step();
        wreq_valid = 0;
        rst = 0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_burst, 0);
        chk("reset_valids", {wbeat_valid, rbeat_valid, gen_next, wreq_ready, rreq_ready}, 0);
        step();

        // Single write 0x1000 len=3 size=2 INCR.
        wbeat_ready = 1; rbeat_ready = 1;
        send(1, 32'h1000, 8'd3, 3'd2, 2'b01, lb);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_wbeat_valid", wbeat_valid, 1);
            chk("t1_wbeat_addr", wbeat_addr, 32'h1000 + 32'(4 * i));
            chk("t1_wbeat_last", wbeat_last, i == 3);
            chk("t1_rbeat_valid", rbeat_valid, 0);
            step();
        end
        @(negedge clk);
        chk("t1_idle_after", {busy, wbeat_valid}, 0);
        step();

        // Both sides requesting straight out of reset, twice each.
        rst = 1;
        grant_log.delete();
        fork
            begin send(1, 32'h2000, 8'd1, 3'd2, 2'b01, lb); send(1, 32'h2100, 8'd1, 3'd2, 2'b01, lb); end
            begin send(0, 32'h3000, 8'd1, 3'd2, 2'b01, lb); send(0, 32'h3100, 8'd1, 3'd2, 2'b01, lb); end
            begin step(); step(); rst = 0; end
        join
        wait_idle(100);
        if (PRIO) exp_order = '{1, 1, 2, 2};
        else      exp_order = '{1, 2, 1, 2};
        chk("t2_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("t2_grant_order", grant_log[i], exp_order[i]);

        // len=0 read: one beat, marked last, idle the next cycle.
        send(0, 32'h4000, 8'd0, 3'd3, 2'b01, lb);
        @(negedge clk);
        chk("t3_rbeat", {rbeat_valid, rbeat_last}, 2'b11);
        chk("t3_raddr", rbeat_addr, 32'h4000);
        step();
        @(negedge clk);
        chk("t3_idle", {busy, rbeat_valid}, 0);
        step();

        // len=7 read with random beat backpressure: exactly 8 generator steps.
        n0 = dut_next_cnt;
        send(0, 32'h8000, 8'd7, 3'd1, 2'b01, lb);
        for (int c = 0; c < 300 && busy; c++) begin
            rbeat_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        rbeat_ready = 1;
        wait_idle(50);
        chk("t4_gen_next_pulses", dut_next_cnt - n0, 8);

        // len=255 write: 256 beats without early wrap.
        w0 = dut_wbeats;
        send(1, 32'h10000, 8'd255, 3'd2, 2'b01, lb);
        wait_idle(400);
        chk("t5_len255_beats", dut_wbeats - w0, 256);

        // Reserved burst type runs as INCR and sets the sticky error.
        send(1, 32'h5000, 8'd2, 3'd0, 2'b11, lb);
        chk("t6_launched_burst", lb, 2'b01);
        wait_idle(50);
        @(negedge clk);
        chk("t6_err_set", err_burst, 1);
        step();
        send(0, 32'h5100, 8'd1, 3'd0, 2'b00, lb);
        wait_idle(50);
        @(negedge clk);
        chk("t6_err_sticky", err_burst, 1);
        step();

        // Reset after two of eight beats aborts cleanly.
        send(1, 32'h6000, 8'd7, 3'd2, 2'b01, lb);
        step(); step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("t7_abort_idle", {busy, wbeat_valid, rbeat_valid, err_burst}, 0);
        step();
        w0 = dut_rbeats;
        send(0, 32'h7000, 8'd1, 3'd2, 2'b01, lb);
        wait_idle(50);
        chk("t7_after_abort_beats", dut_rbeats - w0, 2);

        // Randomised traffic against the model.
        w_pend = 0; r_pend = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (wreq_valid && wreq_ready) w_pend = 0;
            if (rreq_valid && rreq_ready) r_pend = 0;
            step();
            wreq_valid = w_pend; rreq_valid = r_pend;
            if (c < 3800) begin
                if (!w_pend && $urandom_range(0, 3) == 0) begin
                    w_pend = 1; wreq_valid = 1;
                    wreq_addr = $urandom; wreq_size = 3'($urandom_range(0, 7));
                    wreq_len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 3));
                    wreq_burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
                end
                if (!r_pend && $urandom_range(0, 3) == 0) begin
                    r_pend = 1; rreq_valid = 1;
                    rreq_addr = $urandom; rreq_size = 3'($urandom_range(0, 7));
                    rreq_len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 3));
                    rreq_burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
                end
                wbeat_ready = ($urandom_range(0, 3) != 0);
                rbeat_ready = ($urandom_range(0, 3) != 0);
            end else begin
                wbeat_ready = 1; rbeat_ready = 1;
            end
        end
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
